// File: rtl/a23_copro_master_if.sv
// Execute-stage request/response and CP15 coprocessor lines for a23_copro_master.
// master = the initiator view; slave = the execute stage plus coprocessor view.
interface a23_copro_master_if;
  logic        i_fetch_stall;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_write;
  logic [3:0]  i_req_num;
  logic [2:0]  i_req_opcode1;
  logic [2:0]  i_req_opcode2;
  logic [3:0]  i_req_crn;
  logic [3:0]  i_req_crm;
  logic [31:0] i_req_wdata;
  logic [1:0]  o_copro_operation;
  logic [3:0]  o_copro_num;
  logic [2:0]  o_copro_opcode1;
  logic [2:0]  o_copro_opcode2;
  logic [3:0]  o_copro_crn;
  logic [3:0]  o_copro_crm;
  logic [31:0] o_copro_write_data;
  logic [31:0] i_copro_read_data;
  logic        i_cache_busy;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_undef;
  logic        o_rsp_timeout;

  modport master (
    input  i_fetch_stall, i_req_valid, i_req_write, i_req_num, i_req_opcode1, i_req_opcode2,
           i_req_crn, i_req_crm, i_req_wdata, i_copro_read_data, i_cache_busy, i_rsp_ready,
    output o_req_ready, o_copro_operation, o_copro_num, o_copro_opcode1, o_copro_opcode2,
           o_copro_crn, o_copro_crm, o_copro_write_data, o_rsp_valid, o_rsp_rdata,
           o_rsp_undef, o_rsp_timeout
  );

  modport slave (
    output i_fetch_stall, i_req_valid, i_req_write, i_req_num, i_req_opcode1, i_req_opcode2,
           i_req_crn, i_req_crm, i_req_wdata, i_copro_read_data, i_cache_busy, i_rsp_ready,
    input  o_req_ready, o_copro_operation, o_copro_num, o_copro_opcode1, o_copro_opcode2,
           o_copro_crn, o_copro_crm, o_copro_write_data, o_rsp_valid, o_rsp_rdata,
           o_rsp_undef, o_rsp_timeout
  );
endinterface

// File: rtl/a23_copro_master.sv
// Single-outstanding CP15 MCR/MRC initiator; accept->rsp MCR 2, MRC 3, undef 1 (+1 per stalled issue).
// Ready only in IDLE, response held until i_rsp_ready; A23_COPRO_FLUSH_WAIT_EN makes FLUSH wait on i_cache_busy.
module a23_copro_master #(
  parameter int unsigned FLUSH_TIMEOUT = 255
) (
  input logic                i_clk,
  input logic                i_rst,
  a23_copro_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, FLUSH, RESP} state_t;

  state_t      state, state_nxt;
  logic        req_write;
  logic [3:0]  num_q, crn_q, crm_q;
  logic [2:0]  op1_q, op2_q;
  logic [31:0] wdata_q, rdata_q;
  logic        undef_q, tmo_q;
  logic        req_ready, rsp_valid;
  logic [1:0]  operation;
  logic        accept, flush_done, flush_tmo;

  assign accept = bus.i_req_valid && req_ready;

`ifdef A23_COPRO_FLUSH_WAIT_EN
  logic [7:0] flush_cnt;

  assign flush_tmo  = bus.i_cache_busy && (flush_cnt == 8'(FLUSH_TIMEOUT - 1));
  assign flush_done = !bus.i_cache_busy || flush_tmo;

  // Counter idles at zero outside FLUSH, so it is already cleared on entry.
  always_ff @(posedge i_clk) begin
    if (i_rst)                flush_cnt <= '0;
    else if (state != FLUSH)  flush_cnt <= '0;
    else                      flush_cnt <= flush_cnt + 8'd1;
  end
`else
  logic unused_busy;
  assign unused_busy = bus.i_cache_busy;
  assign flush_tmo   = 1'b0;
  assign flush_done  = 1'b1;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (bus.i_req_num != 4'd15) ? RESP : ISSUE;
      ISSUE:   if (!bus.i_fetch_stall) begin
                 if (!req_write)          state_nxt = CAPTURE;
                 else if (crn_q == 4'd1)  state_nxt = FLUSH;
                 else                     state_nxt = RESP;
               end
      CAPTURE: state_nxt = RESP;
      FLUSH:   if (flush_done) state_nxt = RESP;
      RESP:    if (bus.i_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    operation = 2'd0;
    case (state)
      IDLE:    req_ready = 1'b1;
      ISSUE:   operation = req_write ? 2'd2 : 2'd1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      req_write <= 1'b0;
      num_q     <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      crn_q     <= '0;
      crm_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      undef_q   <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      if (accept) begin
        req_write <= bus.i_req_write;
        num_q     <= bus.i_req_num;
        op1_q     <= bus.i_req_opcode1;
        op2_q     <= bus.i_req_opcode2;
        crn_q     <= bus.i_req_crn;
        crm_q     <= bus.i_req_crm;
        wdata_q   <= bus.i_req_wdata;
        rdata_q   <= '0;
        undef_q   <= (bus.i_req_num != 4'd15);
        tmo_q     <= 1'b0;
      end
      if (state == CAPTURE)             rdata_q <= bus.i_copro_read_data;
      if (state == FLUSH && flush_tmo)  tmo_q   <= 1'b1;
      if (state == RESP && bus.i_rsp_ready) begin
        undef_q <= 1'b0;
        tmo_q   <= 1'b0;
      end
    end
  end

  assign bus.o_req_ready        = req_ready;
  assign bus.o_rsp_valid        = rsp_valid;
  assign bus.o_copro_operation  = operation;
  assign bus.o_copro_num        = num_q;
  assign bus.o_copro_opcode1    = op1_q;
  assign bus.o_copro_opcode2    = op2_q;
  assign bus.o_copro_crn        = crn_q;
  assign bus.o_copro_crm        = crm_q;
  assign bus.o_copro_write_data = wdata_q;
  assign bus.o_rsp_rdata        = rdata_q;
  assign bus.o_rsp_undef        = undef_q;
  assign bus.o_rsp_timeout      = tmo_q;
endmodule

// File: tb/tb_a23_copro_master.sv
// Bench for a23_copro_master: directed vector table, reset corner sequences, randomized transactions vs a latency model.
module tb_a23_copro_master;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  a23_copro_master_if bus();

  a23_copro_master #(.FLUSH_TIMEOUT(TMO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.master)
  );

  typedef struct {
    logic        wr;
    logic [3:0]  num;
    logic [3:0]  crn;
    logic [31:0] wdata;
    logic [31:0] rd_in;
    int          s;    // stalled ISSUE cycles
    int          b;    // busy cycles seen in FLUSH
    int          h;    // cycles rsp_ready held low in RESP
    int          lat;  // accept edge to rsp_valid, counting the accept edge
    logic [31:0] er;
    logic        eu;
    logic        et;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [3:0] num, input logic [3:0] crn,
                              input logic [31:0] wdata, input logic [31:0] rd_in,
                              input int s, input int b, input int h, input int lat,
                              input logic [31:0] er, input logic eu, input logic et);
    vec_t v;
    v.wr = wr; v.num = num; v.crn = crn; v.wdata = wdata; v.rd_in = rd_in;
    v.s = s; v.b = b; v.h = h; v.lat = lat; v.er = er; v.eu = eu; v.et = et;
    return v;
  endfunction

  // Response timing from the operation rules: 1 for undefined coprocessors, otherwise
  // accept + issue (+ stalls) followed by a capture, a flush, or nothing.
  function automatic vec_t model(input vec_t vi);
    vec_t v;
    int   f;
    v = vi;
    v.er = 32'd0; v.et = 1'b0; v.eu = (vi.num != 4'd15);
    if (v.eu)             v.lat = 1;
    else if (!vi.wr) begin v.lat = 3 + vi.s; v.er = vi.rd_in; end
    else if (vi.crn != 4'd1) v.lat = 2 + vi.s;
    else begin
`ifdef A23_COPRO_FLUSH_WAIT_EN
      f    = (vi.b < TMO) ? vi.b + 1 : TMO;
      v.et = (vi.b >= TMO);
`else
      f = 1;
`endif
      v.lat = 2 + vi.s + f;
    end
    return v;
  endfunction

  task automatic drive_idle();
    bus.i_req_valid = 1'b0; bus.i_req_write = 1'b0; bus.i_req_num = 4'd0;
    bus.i_req_opcode1 = 3'd0; bus.i_req_opcode2 = 3'd0; bus.i_req_crn = 4'd0;
    bus.i_req_crm = 4'd0; bus.i_req_wdata = 32'd0; bus.i_copro_read_data = 32'd0;
    bus.i_cache_busy = 1'b0; bus.i_fetch_stall = 1'b0; bus.i_rsp_ready = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_txn(input vec_t v, input string tag);
    logic [2:0] o1, o2;
    logic [3:0] crm;
    int         k;
    o1 = 3'($urandom); o2 = 3'($urandom); crm = 4'($urandom);
    chk({tag, ".ready_idle"}, 32'(bus.o_req_ready), 32'd1);
    bus.i_req_valid = 1'b1; bus.i_req_write = v.wr; bus.i_req_num = v.num;
    bus.i_req_opcode1 = o1; bus.i_req_opcode2 = o2; bus.i_req_crn = v.crn;
    bus.i_req_crm = crm; bus.i_req_wdata = v.wdata; bus.i_rsp_ready = 1'b0;
    bus.i_copro_read_data = $urandom;
    bus.i_fetch_stall = 1'($urandom); bus.i_cache_busy = 1'($urandom);
    for (int c = 0; c <= v.lat - 1 + v.h; c++) begin
      @(negedge clk);
      chk({tag, ".op"}, 32'(bus.o_copro_operation),
          (!v.eu && c <= v.s) ? (v.wr ? 32'd2 : 32'd1) : 32'd0);
      chk({tag, ".rsp_valid"}, 32'(bus.o_rsp_valid), 32'(c >= v.lat - 1));
      chk({tag, ".ready_busy"}, 32'(bus.o_req_ready), 32'd0);
      if (c >= v.lat - 1) begin
        chk({tag, ".rdata"}, bus.o_rsp_rdata, v.er);
        chk({tag, ".undef"}, 32'(bus.o_rsp_undef), 32'(v.eu));
        chk({tag, ".timeout"}, 32'(bus.o_rsp_timeout), 32'(v.et));
      end
      if (c == v.lat - 1) begin
        chk({tag, ".num"}, 32'(bus.o_copro_num), 32'(v.num));
        chk({tag, ".opc1"}, 32'(bus.o_copro_opcode1), 32'(o1));
        chk({tag, ".opc2"}, 32'(bus.o_copro_opcode2), 32'(o2));
        chk({tag, ".crn"}, 32'(bus.o_copro_crn), 32'(v.crn));
        chk({tag, ".crm"}, 32'(bus.o_copro_crm), 32'(crm));
        chk({tag, ".wdata"}, bus.o_copro_write_data, v.wdata);
      end
      k = c + 1;
      bus.i_fetch_stall = (k <= v.s) ? 1'b1 : (k == v.s + 1) ? 1'b0 : 1'($urandom);
      bus.i_cache_busy = (k >= v.s + 2 && k <= v.s + 1 + v.b) ? 1'b1 :
                         (k == v.s + 2 + v.b) ? 1'b0 : 1'($urandom);
      bus.i_copro_read_data = (k == v.s + 2) ? v.rd_in : $urandom;
      // Competing request while busy must never be latched.
      bus.i_req_valid = 1'b1; bus.i_req_write = 1'($urandom); bus.i_req_num = 4'($urandom);
      bus.i_req_crn = 4'($urandom); bus.i_req_wdata = $urandom;
      if (c == v.lat - 1 + v.h) begin
        bus.i_rsp_ready = 1'b1;
        bus.i_req_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk({tag, ".rsp_done"}, 32'(bus.o_rsp_valid), 32'd0);
    chk({tag, ".ready_back"}, 32'(bus.o_req_ready), 32'd1);
    chk({tag, ".undef_clr"}, 32'(bus.o_rsp_undef), 32'd0);
    chk({tag, ".tmo_clr"}, 32'(bus.o_rsp_timeout), 32'd0);
    chk({tag, ".op_idle"}, 32'(bus.o_copro_operation), 32'd0);
    drive_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    vec_t v;
    drive_idle();
    tbl[0] = mk(1'b0, 4'd15, 4'd0, 32'h0, 32'h41560300, 0, 0, 0, 3, 32'h41560300, 1'b0, 1'b0);
    tbl[1] = mk(1'b1, 4'd15, 4'd3, 32'hFFFF0000, 32'h0, 2, 0, 0, 4, 32'h0, 1'b0, 1'b0);
    tbl[2] = mk(1'b0, 4'd14, 4'd0, 32'h0, 32'h12345678, 0, 0, 0, 1, 32'h0, 1'b1, 1'b0);
    tbl[3] = mk(1'b0, 4'd15, 4'd5, 32'h0, 32'hCAFEF00D, 1, 0, 3, 4, 32'hCAFEF00D, 1'b0, 1'b0);
    tbl[4] = mk(1'b1, 4'd3, 4'd1, 32'hA5A5A5A5, 32'h0, 0, 0, 2, 1, 32'h0, 1'b1, 1'b0);
`ifdef A23_COPRO_FLUSH_WAIT_EN
    tbl[5] = mk(1'b1, 4'd15, 4'd1, 32'h00000001, 32'h0, 0, 2, 0, 5, 32'h0, 1'b0, 1'b0);
    tbl[6] = mk(1'b1, 4'd15, 4'd1, 32'h00001000, 32'h0, 0, 20, 1, 6, 32'h0, 1'b0, 1'b1);
    tbl[7] = mk(1'b1, 4'd15, 4'd1, 32'h0000FFFF, 32'h0, 2, 1, 0, 6, 32'h0, 1'b0, 1'b0);
`else
    tbl[5] = mk(1'b1, 4'd15, 4'd1, 32'h00000001, 32'h0, 0, 2, 0, 3, 32'h0, 1'b0, 1'b0);
    tbl[6] = mk(1'b1, 4'd15, 4'd1, 32'h00001000, 32'h0, 0, 20, 1, 3, 32'h0, 1'b0, 1'b0);
    tbl[7] = mk(1'b1, 4'd15, 4'd1, 32'h0000FFFF, 32'h0, 2, 1, 0, 5, 32'h0, 1'b0, 1'b0);
`endif

    repeat (3) @(negedge clk);
    chk("reset.ready", 32'(bus.o_req_ready), 32'd1);
    chk("reset.rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("reset.op", 32'(bus.o_copro_operation), 32'd0);
    chk("reset.num", 32'(bus.o_copro_num), 32'd0);
    chk("reset.wdata", bus.o_copro_write_data, 32'd0);
    chk("reset.rdata", bus.o_rsp_rdata, 32'd0);
    chk("reset.undef", 32'(bus.o_rsp_undef), 32'd0);
    chk("reset.timeout", 32'(bus.o_rsp_timeout), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Reset while stalled in ISSUE.
    bus.i_req_valid = 1'b1; bus.i_req_num = 4'd15; bus.i_req_crn = 4'd5;
    bus.i_req_write = 1'b0; bus.i_fetch_stall = 1'b1;
    @(negedge clk);
    chk("rst_issue.op_before", 32'(bus.o_copro_operation), 32'd1);
    rst = 1'b1; bus.i_req_valid = 1'b0;
    @(negedge clk);
    chk("rst_issue.op", 32'(bus.o_copro_operation), 32'd0);
    chk("rst_issue.rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("rst_issue.ready", 32'(bus.o_req_ready), 32'd1);
    chk("rst_issue.crn", 32'(bus.o_copro_crn), 32'd0);
    rst = 1'b0; bus.i_fetch_stall = 1'b0;
    run_txn(tbl[0], "after_rst_issue");

    // Reset while holding a response.
    bus.i_req_valid = 1'b1; bus.i_req_num = 4'd7;
    @(negedge clk);
    chk("rst_resp.valid_before", 32'(bus.o_rsp_valid), 32'd1);
    chk("rst_resp.undef_before", 32'(bus.o_rsp_undef), 32'd1);
    rst = 1'b1; bus.i_req_valid = 1'b0;
    @(negedge clk);
    chk("rst_resp.rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("rst_resp.ready", 32'(bus.o_req_ready), 32'd1);
    chk("rst_resp.undef", 32'(bus.o_rsp_undef), 32'd0);
    chk("rst_resp.op", 32'(bus.o_copro_operation), 32'd0);
    rst = 1'b0;
    run_txn(tbl[3], "after_rst_resp");

    for (int i = 0; i < 60; i++) begin
      v.wr    = 1'($urandom);
      v.num   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd15;
      v.crn   = ($urandom_range(0, 2) == 0) ? 4'd1 : 4'($urandom);
      v.wdata = $urandom;
      v.rd_in = $urandom;
      v.s     = $urandom_range(0, 3);
      v.b     = $urandom_range(0, 6);
      v.h     = $urandom_range(0, 3);
      run_txn(model(v), $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/a23_copro_master.md
Name: a23_copro_master

Overview:
- Core-side initiator for the CP15 register interface: accepts one MCR/MRC request at a time from the execute stage and drives the coprocessor operation, register-select and write-data lines.
- Captures read data and returns it with an undefined-coprocessor flag.
- Sequences cache-flush completion after a CP15 register 1 write.
- Sits between the decode/execute logic and the CP15 coprocessor, sharing its clock and fetch-stall.

Parameters:
- FLUSH_TIMEOUT, 255, maximum FLUSH-state cycles (1..255) before forced completion; counter width 8 bits.

Ports:
- i_clk  in  1  core clock
- i_rst  in  1  synchronous active-high reset
- i_fetch_stall  in  1  global stall; coprocessor samples only when low
- i_req_valid  in  1  request present
- o_req_ready  out  1  request accepted on this edge when valid&ready
- i_req_write  in  1  1=MCR (write), 0=MRC (read)
- i_req_num  in  4  coprocessor number
- i_req_opcode1  in  3  opcode1 field
- i_req_opcode2  in  3  opcode2 field
- i_req_crn  in  4  register number
- i_req_crm  in  4  crm field
- i_req_wdata  in  32  MCR data
- o_copro_operation  out  2  0=idle, 1=read, 2=write
- o_copro_num  out  4  to coprocessor
- o_copro_opcode1  out  3  to coprocessor
- o_copro_opcode2  out  3  to coprocessor
- o_copro_crn  out  4  to coprocessor
- o_copro_crm  out  4  to coprocessor
- o_copro_write_data  out  32  to coprocessor
- i_copro_read_data  in  32  registered read data from coprocessor
- i_cache_busy  in  1  cache flush in progress
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  response consumed
- o_rsp_rdata  out  32  MRC result (0 for MCR/undef)
- o_rsp_undef  out  1  i_req_num != 15
- o_rsp_timeout  out  1  flush wait hit FLUSH_TIMEOUT

Behaviour:
- Reset: state IDLE; o_req_ready=1; o_rsp_valid=0; o_copro_operation=0; all o_copro_* fields, o_rsp_rdata, o_rsp_undef, o_rsp_timeout=0; flush counter=0. Reset mid-operation abandons the request without issuing further operations; any partially issued write is not retried.
- States: IDLE, ISSUE, CAPTURE, FLUSH, RESP.
- o_req_ready=1 only in IDLE; o_req_ready ignores i_fetch_stall. One request is outstanding at a time; no back-to-back issue.
- IDLE, on valid&ready:
  - Latch all request fields into the o_copro_* registers.
  - If num!=15: go to RESP with undef=1, rdata=0; no operation is driven.
  - Otherwise: go to ISSUE.
- ISSUE:
  - o_copro_operation = write?2:1; every other state drives 0.
  - Remain in ISSUE while i_fetch_stall=1.
  - On the first non-stalled edge:
    - Write with crn==1: go to FLUSH.
    - Other write: go to RESP (rdata=0).
    - Read: go to CAPTURE.
- CAPTURE: crn/fields held; at the next edge, unconditionally latch i_copro_read_data into o_rsp_rdata; go to RESP.
- FLUSH: see Optional Feature.
- RESP:
  - o_rsp_valid=1; hold all response outputs stable until i_rsp_ready=1.
  - Then clear o_rsp_valid, o_rsp_undef and o_rsp_timeout; go to IDLE.
  - o_copro_* field registers keep their last values.
- Latency, accept edge to o_rsp_valid with no stall: MCR 2 cycles; MRC 3 cycles; undef 1 cycle. Each stalled ISSUE cycle adds 1.
- Simultaneous events:
  - i_rst dominates everything.
  - i_fetch_stall in CAPTURE, FLUSH or RESP has no effect.

Optional Feature:
- Macro A23_COPRO_FLUSH_WAIT_EN.
- Defined:
  - FLUSH loads counter=0 on entry and increments each cycle.
  - Exit to RESP on the first edge where i_cache_busy=0.
  - Or, when the counter reaches FLUSH_TIMEOUT-1 with busy still 1, exit to RESP with o_rsp_timeout=1.
- Undefined:
  - FLUSH lasts exactly 1 cycle then goes to RESP.
  - i_cache_busy is ignored; o_rsp_timeout is held 0.

Test Plan:
1. MRC with num=15, crn=0, coprocessor returning 0x41560300, no stall -> operation=1 for 1 cycle; o_rsp_valid 3 cycles after accept; rdata=0x41560300; undef=0.
2. MCR with crn=3, wdata=0xFFFF0000, i_fetch_stall high 2 cycles during ISSUE -> operation=2 held 3 cycles; write_data=0xFFFF0000; rsp_valid 4 cycles after accept; rdata=0.
3. MRC with num=14 -> operation stays 0; rsp_valid 1 cycle after accept; undef=1; rdata=0.
4. With A23_COPRO_FLUSH_WAIT_EN, MCR crn=1, i_cache_busy high 5 cycles after ISSUE -> rsp_valid the cycle after busy falls; timeout=0. Repeat with FLUSH_TIMEOUT=4 and busy stuck high -> timeout=1 after 4 FLUSH cycles.
5. Hold i_rsp_ready=0 for 3 cycles in RESP while i_req_valid=1 -> rsp outputs stable; o_req_ready=0; no new operation until 1 cycle after i_rsp_ready.
6. Assert i_rst during ISSUE and during RESP -> next cycle operation=0, rsp_valid=0, o_req_ready=1; a following MRC completes normally.
